pipeline_hazard_ctrl: RTL

Parametrised pipeline control unit that centralises stall, bubble, flush and operand-forwarding decisions for the ARM core pipeline. It keeps its own scoreboard of in-flight writers from EXE onward, so it no longer needs destination/enable taps from every stage register. It generalises forwarding depth and register-address width, and adds a whole-pipeline memory-wait stall plus saturating stall/flush performance counters. It sits beside the ID stage: it drives IF/ID/EXE register control and the EXE operand muxes.

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall / bubble / flush / operand-forwarding control
//               for the ARM core pipeline. Keeps a private scoreboard of the
//               in-flight instructions from EXE onward and derives hazard and
//               forward-select decisions from it. Also provides a whole-
//               pipeline memory-wait stall and saturating perf counters.
//               Optional macro PIPE_FWD_EN: when defined, forwarding compares
//               and the frwrd_mode behaviour are built in; when undefined,
//               sel_src1/sel_src2 are tied to 0 and hazards always use the
//               full-stall rule.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_FWD    = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(NUM_FWD + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frwrd_mode,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    output logic                  freeze,
    output logic                  bubble,
    output logic                  flush,
    output logic                  stall_all,
    output logic [SEL_W-1:0]      sel_src1,
    output logic [SEL_W-1:0]      sel_src2,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    // Scoreboard: bit/entry k is slot k (0 = EXE, k = k stages after EXE).
    logic [NUM_FWD:0]                 r_valid;
    logic [NUM_FWD:0]                 r_wb_en;
    logic [NUM_FWD:0]                 r_mem_read;
    logic [NUM_FWD:0]                 r_two_src;
    logic [NUM_FWD:0][REG_ADDR_W-1:0] r_dest;
    logic [NUM_FWD:0][REG_ADDR_W-1:0] r_src1;
    logic [NUM_FWD:0][REG_ADDR_W-1:0] r_src2;

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic [NUM_FWD:0] w_writer;
    logic [NUM_FWD:0] w_id_hit;
    logic             w_hz_full;
    logic             w_hazard;
    logic             w_id_blocked;
    logic             w_ins_valid;

    assign w_writer = r_valid & r_wb_en;

    // Which slots hold a writer to one of the ID instruction's operands.
    always_comb begin
        w_id_hit = '0;
        for (int k = 0; k <= NUM_FWD; k++) begin
            w_id_hit[k] = w_writer[k] &&
                          ((r_dest[k] == id_src1) ||
                           (id_two_src && (r_dest[k] == id_src2)));
        end
    end

    // The oldest slot writes the register file in the same cycle
    // (write-before-read), so it never causes a stall.
    assign w_hz_full = |w_id_hit[NUM_FWD-1:0];

`ifdef PIPE_FWD_EN
    logic w_hz_load_use;

    // With forwarding only a load sitting in EXE forces a stall.
    assign w_hz_load_use = w_id_hit[0] && r_mem_read[0];
    assign w_hazard      = frwrd_mode ? w_hz_load_use : w_hz_full;

    // Forward select for the EXE operands; iterate oldest to youngest so the
    // youngest matching writer overrides.
    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        if (frwrd_mode && r_valid[0]) begin
            for (int k = NUM_FWD; k >= 1; k--) begin
                if (w_writer[k] && (r_dest[k] == r_src1[0]))
                    sel_src1 = SEL_W'(k);
                if (r_two_src[0] && w_writer[k] && (r_dest[k] == r_src2[0]))
                    sel_src2 = SEL_W'(k);
            end
        end
    end
`else
    logic w_unused_fwd;

    // Forwarding is not built: operands always come from the register file.
    assign w_hazard     = w_hz_full;
    assign sel_src1     = '0;
    assign sel_src2     = '0;
    assign w_unused_fwd = ^{frwrd_mode, r_mem_read, r_two_src, r_src1, r_src2};
`endif

    // Priority: memory wait, then taken branch, then data hazard.
    assign stall_all    = mem_busy;
    assign flush        = !mem_busy && branch_taken;
    assign w_id_blocked = w_hazard && id_valid;
    assign freeze       = !mem_busy && !branch_taken && w_id_blocked;
    assign bubble       = freeze;

    // A flush or a hazard injects a bubble into EXE instead of the ID op.
    assign w_ins_valid  = id_valid && !branch_taken && !w_id_blocked;

    // Scoreboard shift: everything advances unless memory holds the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_wb_en    <= '0;
            r_mem_read <= '0;
            r_two_src  <= '0;
            r_dest     <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
        end else if (!mem_busy) begin
            r_valid    <= {r_valid[NUM_FWD-1:0],    w_ins_valid};
            r_wb_en    <= {r_wb_en[NUM_FWD-1:0],    id_wb_en};
            r_mem_read <= {r_mem_read[NUM_FWD-1:0], id_mem_read};
            r_two_src  <= {r_two_src[NUM_FWD-1:0],  id_two_src};
            r_dest     <= {r_dest[NUM_FWD-1:0],     id_dest};
            r_src1     <= {r_src1[NUM_FWD-1:0],     id_src1};
            r_src2     <= {r_src2[NUM_FWD-1:0],     id_src2};
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if ((stall_all || freeze) && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (flush && (r_flush_count != {CNT_W{1'b1}}))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire
